// File: rtl/dmem_pkg.sv
// Shared constants, FSM state type and address helpers for the data-memory responder.
package dmem_pkg;

  // 512 words of 32 bits, addressed by byte address bits [10:2]
  localparam int DEPTH_LOG2   = 9;
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int WINDOW_BYTES = 4 << DEPTH_LOG2;
  localparam int WINDOW_LOG2  = $clog2(WINDOW_BYTES);

  // Wait-state counter width (WAIT_STATES is limited to 0..7)
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the address falls inside the window at base and is word aligned
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] base);
    return (addr[31:WINDOW_LOG2] == base[31:WINDOW_LOG2]) && (addr[1:0] == 2'b00);
  endfunction

  // Word index of a byte address inside the window
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] addr);
    return addr[WINDOW_LOG2-1:2];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a core's memory master and the data-memory responder.
interface dmem_responder_if;

  logic        m_sel;
  logic        m_rnw;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] s_data;
  logic        s_ready;
  logic        s_err;

  modport master (
    output m_sel, m_rnw, m_addr, m_data,
    input  s_data, s_ready, s_err
  );

  modport slave (
    input  m_sel, m_rnw, m_addr, m_data,
    output s_data, s_ready, s_err
  );

endinterface

// File: rtl/dmem_array.sv
// 512 x 32 storage: one write port and two registered read ports (bus, debug).
// Reads return the pre-write value on a same-word collision. Contents are
// never reset; only the read output registers clear on reset.
module dmem_array
  import dmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [DEPTH_LOG2-1:0] bus_addr_i,
  output logic [31:0]           bus_data_o,
  input  logic [DEPTH_LOG2-1:0] dbg_addr_i,
  output logic [31:0]           dbg_data_o
);

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_addr [2];
  logic [31:0]           rd_data [2];

  assign rd_addr[0]  = bus_addr_i;
  assign rd_addr[1]  = dbg_addr_i;
  assign bus_data_o  = rd_data[0];
  assign dbg_data_o  = rd_data[1];

  // Single write port
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Identical registered read ports, one per consumer
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [31:0] data_q;

    // Read every cycle; output register clears on reset
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        data_q <= '0;
      end else begin
        data_q <= mem_q[rd_addr[gi]];
      end
    end

    assign rd_data[gi] = data_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request in IDLE, optionally waits
// WAIT_STATES cycles, then gives a one-cycle response. Out-of-window or
// misaligned requests answer with s_err and never touch the storage.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_responder_if.slave       bus,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam bit              NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DEPTH_LOG2-1:0] req_idx_q;
  logic                  req_rnw_q;
  logic [31:0]           req_data_q;
  logic                  req_ok_q;
  logic                  s_ready_q;
  logic                  s_err_q;
  logic [31:0]           s_hold_q;

  logic                  in_ok;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [31:0]           wr_data;
  logic [DEPTH_LOG2-1:0] bus_rd_idx;
  logic [31:0]           bus_rd_data;
  logic [31:0]           resp_data;

  assign in_ok = addr_ok(bus.m_addr, BASE_ADDR);

  // While idle the read port follows the live address so a zero-wait read
  // has its word ready in the response cycle; otherwise use the latched index.
  assign bus_rd_idx = (state_q == ST_IDLE) ? word_idx(bus.m_addr) : req_idx_q;

  // Write strobe fires on the edge that enters RESP, and never under reset
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx_q;
    wr_data = req_data_q;
    if (rst_n) begin
      if (NO_WAIT && (state_q == ST_IDLE) && bus.m_sel) begin
        wr_en   = !bus.m_rnw && in_ok;
        wr_idx  = word_idx(bus.m_addr);
        wr_data = bus.m_data;
      end else if ((state_q == ST_WAIT) && (cnt_q == '0)) begin
        wr_en   = !req_rnw_q && req_ok_q;
      end
    end
  end

  dmem_array u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_idx),
    .wr_data_i  (wr_data),
    .bus_addr_i (bus_rd_idx),
    .bus_data_o (bus_rd_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  // Only a valid read returns memory contents; writes and errors return zero
  assign resp_data   = (req_rnw_q && req_ok_q) ? bus_rd_data : 32'h0;
  assign bus.s_data  = s_ready_q ? resp_data : s_hold_q;
  assign bus.s_ready = s_ready_q;
  assign bus.s_err   = s_err_q;

  // Request FSM with registered response strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_idx_q  <= '0;
      req_rnw_q  <= 1'b0;
      req_data_q <= '0;
      req_ok_q   <= 1'b0;
      s_ready_q  <= 1'b0;
      s_err_q    <= 1'b0;
      s_hold_q   <= '0;
    end else begin
      s_ready_q <= 1'b0;
      s_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.m_sel) begin
            req_idx_q  <= word_idx(bus.m_addr);
            req_rnw_q  <= bus.m_rnw;
            req_data_q <= bus.m_data;
            req_ok_q   <= in_ok;
            if (NO_WAIT) begin
              state_q   <= ST_RESP;
              s_ready_q <= 1'b1;
              s_err_q   <= !in_ok;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q   <= ST_RESP;
            s_ready_q <= 1'b1;
            s_err_q   <= !req_ok_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          // Keep the response word visible on s_data after the strobe drops
          state_q  <= ST_IDLE;
          s_hold_q <= resp_data;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1, giving the number of extra cycles before the response (legal range 0..7).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte base of the 2 KiB window (bits [10:0] ignored).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 m_sel  input  1  request strobe from the core's memory master.
REQ-006 m_rnw  input  1  1 = read, 0 = write.
REQ-007 m_addr  input  32  byte address.
REQ-008 m_data  input  32  write data.
REQ-009 s_data  output  32  read response data.
REQ-010 s_ready  output  1  one-cycle response strobe.
REQ-011 s_err  output  1  error flag, qualified by s_ready.
REQ-012 dbg_addr  input  9  debug word index, independent of the bus.
REQ-013 dbg_data  output  32  debug read data.

Function
REQ-014 Storage SHALL be 512 x 32-bit words, indexed by m_addr[10:2].
REQ-015 A request SHALL be in range when m_addr[31:11] == BASE_ADDR[31:11] and aligned when m_addr[1:0] == 2'b00; otherwise it is an error request.
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 In IDLE, m_sel high at edge N SHALL latch m_addr, m_rnw and m_data, then go to RESP if WAIT_STATES == 0, else to WAIT with the counter loaded to WAIT_STATES-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-019 RESP SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-020 s_ready SHALL be high only in RESP, i.e. cycle N+1+WAIT_STATES.
REQ-021 m_sel SHALL be ignored outside IDLE; no queuing.
REQ-022 Maximum throughput SHALL be one request per WAIT_STATES+2 cycles.
REQ-023 A valid write SHALL update the array at the edge that enters RESP.
REQ-024 During a write response, s_data SHALL be 0.
REQ-025 A valid read SHALL drive the addressed word on s_data during RESP.
REQ-026 Outside RESP, s_data SHALL hold its last value.
REQ-027 An error request SHALL NOT modify the array, and SHALL respond with s_data = 0 and s_err = 1 during RESP.
REQ-028 s_err SHALL be 0 whenever s_ready is 0.
REQ-029 dbg_data SHALL present the word at dbg_addr with one-cycle latency, every cycle, regardless of FSM state.
REQ-030 When a debug read and a bus write hit the same word on the same edge, dbg_data SHALL return the old value.

Reset
REQ-031 rst_n low at a clock edge SHALL force state IDLE, counter 0, s_ready 0, s_err 0, s_data 0 and dbg_data 0.
REQ-032 Array contents SHALL NOT be reset.
REQ-033 Reset during WAIT SHALL drop the pending transaction: no write and no s_ready.
REQ-034 m_sel sampled while rst_n is low SHALL be ignored.

Structure
REQ-035 The state enum, DEPTH_LOG2 = 9 and the window-size constant SHALL live in a shared package dmem_pkg.
REQ-036 The storage SHALL be a sub-module dmem_array with one write port and two synchronous read ports (bus and debug), each read port registered.
REQ-037 The FSM, address decode and response registers SHALL reside in dmem_responder.

Verification
REQ-038 Write then read, WAIT_STATES=1: write 32'hCAFE_0001 to 0x0000_0010, then read 0x0000_0010 -> s_ready on cycle N+2 of each request, read s_data = 32'hCAFE_0001, s_err = 0.
REQ-039 Error requests: read 0x0000_0013 -> s_err = 1, s_data = 0; write to 0x0000_0800 -> s_err = 1 and word 0 unchanged (checked via the debug port).
REQ-040 Busy: m_sel held high for 6 cycles with WAIT_STATES=1 -> exactly 2 responses, at cycles 2 and 5.
REQ-041 WAIT_STATES=0: read 0x0000_0004 -> s_ready in cycle N+1; back-to-back requests accepted every 2 cycles.
REQ-042 Reset mid-WAIT (WAIT_STATES=3): rst_n low during a write of 32'h1234_5678 -> no s_ready, target word retains its prior value.
REQ-043 Debug collision: dbg_addr = 4 while a bus write of 32'hA5A5_A5A5 lands on word 4 -> dbg_data shows the old value, then 32'hA5A5_A5A5 one cycle later.
